// File: rtl/sb_pkg.sv
// Shared types for the store buffer sitting between the MIPS core data port
// and data memory.
//   sb_entry_t  : one buffered store {adr, data}
//   sb_state_e  : flush sequencing states
//   word_match  : word-granular address compare (byte offset ignored)
// Entry widths are fixed here; store_buffer's AW/DW must equal SB_AW/SB_DW.
package sb_pkg;

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    typedef struct packed {
        logic [SB_AW-1:0] adr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_RUN   = 2'd0,
        SB_FLUSH = 2'd1,
        SB_DONE  = 2'd2
    } sb_state_e;

    // Stores and loads are word-aligned; bits [1:0] never take part.
    function automatic logic word_match(input logic [SB_AW-1:0] a,
                                        input logic [SB_AW-1:0] b);
        return a[SB_AW-1:2] == b[SB_AW-1:2];
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Posted-write buffer downstream of the core data-memory port.
// Stores are captured in one cycle into a DEPTH-entry circular FIFO and
// drained head-first to memory over valid/ready. Loads see the newest
// buffered store to the same word through ld_hit/ld_data. flush_req drains
// the buffer to empty (new stores stalled) and pulses flush_done once.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   memwrite/dataadr/
//   writedata             core store request (dataadr also used for loads)
//   stall                 core must hold its store this cycle (comb)
//   ld_hit/ld_data        store-to-load forwarding result (comb)
//   flush_req/flush_done  drain-to-empty request / completion pulse
//   mem_valid/mem_adr/
//   mem_data/mem_ready    head entry handshake to data memory
//   count                 occupied entries
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [AW-1:0]              dataadr,
    input  logic [DW-1:0]              writedata,
    output logic                       stall,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_data,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       mem_valid,
    output logic [AW-1:0]              mem_adr,
    output logic [DW-1:0]              mem_data,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    sb_entry_t     ent_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;
    sb_state_e     state_q, state_d;
    logic          full, enq, deq;

    // Full/empty come from count alone; pointers wrap freely (DEPTH is 2^n).
    assign full      = (count_q == CW'(DEPTH));
    // The full test uses the registered count, so a same-cycle dequeue
    // never makes room for the store arriving in that cycle.
    assign stall     = memwrite && (full || state_q == SB_FLUSH);
    assign enq       = memwrite && !stall;
    assign mem_valid = (count_q != '0);
    assign deq       = mem_valid && mem_ready;
    assign count_d   = count_q + CW'(enq) - CW'(deq);

    // Head entry is only overwritten after it is dequeued, so mem_adr and
    // mem_data hold steady under backpressure.
    assign mem_adr    = ent_q[head_q].adr;
    assign mem_data   = ent_q[head_q].data;
    assign count      = count_q;
    assign flush_done = (state_q == SB_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= SB_RUN;
        end else begin
            if (enq) tail_q <= tail_q + PW'(1);
            if (deq) head_q <= head_q + PW'(1);
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Storage needs no reset: slots outside [head, head+count) are ignored.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            ent_q[tail_q] <= '{adr: dataadr, data: writedata};
        end
    end

    // Walk entries oldest to newest so the newest match overwrites older
    // ones. Only the registered contents are searched, so a store entering
    // this cycle becomes visible one cycle later.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q &&
                word_match(ent_q[head_q + PW'(i)].adr, dataadr)) begin
                ld_hit  = 1'b1;
                ld_data = ent_q[head_q + PW'(i)].data;
            end
        end
    end

    // Flush sequencing. FLUSH looks at the next count so a dequeue that
    // empties the buffer in this cycle finishes the flush immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_RUN:   if (flush_req) state_d = SB_FLUSH;
            SB_FLUSH: if (count_d == '0) state_d = SB_DONE;
            SB_DONE:  state_d = SB_RUN;
            default:  state_d = SB_RUN;
        endcase
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset, memwrite, flush_req, mem_ready;
    logic [31:0] dataadr, writedata;
    logic        stall, ld_hit, flush_done, mem_valid;
    logic [31:0] ld_data, mem_adr, mem_data;
    logic [2:0]  count;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .stall(stall), .ld_hit(ld_hit),
        .ld_data(ld_data), .flush_req(flush_req), .flush_done(flush_done),
        .mem_valid(mem_valid), .mem_adr(mem_adr), .mem_data(mem_data),
        .mem_ready(mem_ready), .count(count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: an in-order queue of pending stores plus a flush mode.
    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    localparam int M_RUN = 0, M_FLUSH = 1, M_DONE = 2;
    int   mode = M_RUN;
    logic live = 1'b0;

    // DUT values sampled in the most recent cycle (before its clock edge).
    logic        s_stall, s_hit, s_mv, s_fd;
    logic [31:0] s_ld, s_madr, s_mdata;
    logic [2:0]  s_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, clock, advance model.
    task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic fl, input logic rst);
        logic        e_stall, e_hit;
        logic [31:0] e_ld;
        logic        do_deq, do_enq;
        memwrite = mw; dataadr = a; writedata = d;
        mem_ready = rdy; flush_req = fl; reset = rst;
        #1;
        s_stall = stall; s_hit = ld_hit; s_ld = ld_data; s_mv = mem_valid;
        s_fd = flush_done; s_madr = mem_adr; s_mdata = mem_data; s_cnt = count;
        e_stall = mw && (q.size() == 4 || mode == M_FLUSH);
        e_hit = 1'b0;
        e_ld  = '0;
        foreach (q[i]) if (q[i].adr[31:2] == a[31:2]) begin e_hit = 1'b1; e_ld = q[i].data; end
        if (live) begin
            chk("stall", {31'b0, s_stall}, {31'b0, e_stall});
            chk("count", {29'b0, s_cnt}, q.size());
            chk("mem_valid", {31'b0, s_mv}, {31'b0, q.size() != 0});
            chk("ld_hit", {31'b0, s_hit}, {31'b0, e_hit});
            chk("ld_data", s_ld, e_ld);
            chk("flush_done", {31'b0, s_fd}, {31'b0, mode == M_DONE});
            if (q.size() != 0) begin
                chk("mem_adr", s_madr, q[0].adr);
                chk("mem_data", s_mdata, q[0].data);
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            mode = M_RUN;
        end else begin
            do_deq = (q.size() != 0) && rdy;
            do_enq = mw && !e_stall;
            if (do_deq) void'(q.pop_front());
            if (do_enq) q.push_back('{adr: a, data: d});
            case (mode)
                M_RUN:   if (fl) mode = M_FLUSH;
                M_FLUSH: if (q.size() == 0) mode = M_DONE;
                default: mode = M_RUN;
            endcase
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        mw;
        logic [31:0] a;
        logic        rdy;
        logic        e_stall;
        int          e_cnt;
        logic        e_mv;
        logic [31:0] e_madr;
    } vec_t;
    vec_t tv[10];

    initial begin
        int pulses;
        logic [31:0] ra;

        // Fill to full under backpressure, then drain in order.
        tv[0] = '{1'b1, 32'd0,  1'b0, 1'b0, 0, 1'b0, 32'd0};
        tv[1] = '{1'b1, 32'd4,  1'b0, 1'b0, 1, 1'b1, 32'd0};
        tv[2] = '{1'b1, 32'd8,  1'b0, 1'b0, 2, 1'b1, 32'd0};
        tv[3] = '{1'b1, 32'd12, 1'b0, 1'b0, 3, 1'b1, 32'd0};
        tv[4] = '{1'b1, 32'd16, 1'b0, 1'b1, 4, 1'b1, 32'd0};
        tv[5] = '{1'b0, 32'd0,  1'b1, 1'b0, 4, 1'b1, 32'd0};
        tv[6] = '{1'b0, 32'd0,  1'b1, 1'b0, 3, 1'b1, 32'd4};
        tv[7] = '{1'b0, 32'd0,  1'b1, 1'b0, 2, 1'b1, 32'd8};
        tv[8] = '{1'b0, 32'd0,  1'b1, 1'b0, 1, 1'b1, 32'd12};
        tv[9] = '{1'b0, 32'd0,  1'b1, 1'b0, 0, 1'b0, 32'd0};

        // Reset and reset state.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        live = 1'b1;
        idle(1'b0);
        chk("rst_count", {29'b0, s_cnt}, 32'd0);
        chk("rst_mem_valid", {31'b0, s_mv}, 32'd0);
        chk("rst_flush_done", {31'b0, s_fd}, 32'd0);
        chk("rst_stall", {31'b0, s_stall}, 32'd0);

        // Single store reaches memory one cycle later.
        cyc(1'b1, 32'd80, 32'hFFFFAAFA, 1'b1, 1'b0, 1'b0);
        chk("t1_no_bypass", {31'b0, s_mv}, 32'd0);
        idle(1'b1);
        chk("t1_mv", {31'b0, s_mv}, 32'd1);
        chk("t1_adr", s_madr, 32'd80);
        chk("t1_data", s_mdata, 32'hFFFFAAFA);
        idle(1'b1);
        chk("t1_count", {29'b0, s_cnt}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            cyc(tv[i].mw, tv[i].a, 32'h100 + i, tv[i].rdy, 1'b0, 1'b0);
            chk("tv_stall", {31'b0, s_stall}, {31'b0, tv[i].e_stall});
            chk("tv_count", {29'b0, s_cnt}, tv[i].e_cnt);
            chk("tv_mv", {31'b0, s_mv}, {31'b0, tv[i].e_mv});
            if (tv[i].e_mv) chk("tv_madr", s_madr, tv[i].e_madr);
        end

        // Forwarding: newest match wins, byte offset ignored.
        cyc(1'b1, 32'd84, 32'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'd84, 32'd2, 1'b0, 1'b0, 1'b0);
        chk("t3_prev_hit", {31'b0, s_hit}, 32'd1);
        chk("t3_prev_data", s_ld, 32'd1);
        cyc(1'b0, 32'd84, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t3_hit84", {31'b0, s_hit}, 32'd1);
        chk("t3_data84", s_ld, 32'd2);
        cyc(1'b0, 32'd88, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t3_hit88", {31'b0, s_hit}, 32'd0);
        chk("t3_data88", s_ld, 32'd0);
        cyc(1'b0, 32'd87, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t3_hit87", {31'b0, s_hit}, 32'd1);
        chk("t3_data87", s_ld, 32'd2);
        repeat (3) idle(1'b1);

        // Concurrent enqueue+dequeue at count 2, across pointer wrap.
        cyc(1'b1, 32'd200, 32'hA0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'd204, 32'hA1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'd208 + 4 * i, 32'hB0 + i, 1'b1, 1'b0, 1'b0);
            chk("t4_count", {29'b0, s_cnt}, 32'd2);
            chk("t4_order", s_madr, 32'd200 + 4 * i);
        end
        repeat (3) idle(1'b1);

        // Flush with 3 entries; stores stalled while flushing.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'd300 + 4 * i, i, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 32'd400 + 4 * k, k, 1'b1, 1'b0, 1'b0);
            if (k == 0) chk("t5_stall_in_flush", {31'b0, s_stall}, 32'd1);
            if (s_fd) pulses++;
        end
        chk("t5_pulses", pulses, 32'd1);
        repeat (3) idle(1'b1);

        // Flush on empty buffer: pulse two cycles after request.
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("t5e_fd1", {31'b0, s_fd}, 32'd0);
        idle(1'b1);
        chk("t5e_fd2", {31'b0, s_fd}, 32'd1);
        idle(1'b1);
        chk("t5e_fd3", {31'b0, s_fd}, 32'd0);

        // Reset mid-drain drops pending stores.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'd500 + 4 * i, i, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            chk("t6_mv", {31'b0, s_mv}, 32'd0);
            chk("t6_count", {29'b0, s_cnt}, 32'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ra = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            cyc(1'($urandom_range(0, 1)), ra, $urandom,
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 149) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
